lfsr_checker: RTL



---
 rtl/lfsr_pkg.sv | 29 ++
 rtl/lfsr_checker.sv | 125 ++++++++++++
 2 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared 32-bit LFSR polynomial, next-word function and checker states
package lfsr_pkg;

    localparam int unsigned LFSR_W       = 32;
    localparam logic [31:0] LFSR_DEFAULT = 32'hAAAA_AAAA;

    localparam int unsigned TAP_A = 31;
    localparam int unsigned TAP_B = 21;
    localparam int unsigned TAP_C = 1;
    localparam int unsigned TAP_D = 0;

    // An all-zero register would lock up the shift register, so it restarts from a fixed pattern.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] r);
        logic [LFSR_W-1:0] n;
        if (r == '0) begin
            n = LFSR_DEFAULT;
        end else begin
            n = {r[TAP_A] ^ r[TAP_B] ^ r[TAP_C] ^ r[TAP_D], r[LFSR_W-1:1]};
        end
        return n;
    endfunction

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

endpackage

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising LFSR stream checker with lock state and saturating counts
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned SYNC_MATCHES = 4,
    parameter int unsigned LOSS_THRESH  = 8,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic [31:0]       expected,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int unsigned MW = $clog2(SYNC_MATCHES + 1);
    localparam int unsigned LW = $clog2(LOSS_THRESH + 1);

    chk_state_t        state_q, state_d;
    logic [31:0]       exp_q, exp_d;
    logic [MW-1:0]     match_q, match_d;
    logic [LW-1:0]     miss_q, miss_d;
    logic              pulse_q, pulse_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              word_inc, err_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HUNT;
            exp_q      <= '0;
            match_q    <= '0;
            miss_q     <= '0;
            pulse_q    <= 1'b0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            pulse_q    <= pulse_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        match_d  = match_q;
        miss_d   = miss_q;
        pulse_d  = 1'b0;
        word_inc = 1'b0;
        err_inc  = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    exp_d   = lfsr_next(in_data);
                    match_d = '0;
                    state_d = SYNC;
                end
                SYNC: begin
                    exp_d = lfsr_next(in_data);
                    if (in_data == exp_q) begin
                        match_d = match_q + MW'(1);
                        if (match_d == MW'(SYNC_MATCHES)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    word_inc = 1'b1;
                    if (in_data == exp_q) begin
                        miss_d = '0;
                        exp_d  = lfsr_next(in_data);
                    end else begin
                        // Free-run on our own prediction so one bad word costs one error.
                        err_inc = 1'b1;
                        pulse_d = 1'b1;
                        miss_d  = miss_q + LW'(1);
                        exp_d   = lfsr_next(exp_q);
                        if (miss_d == LW'(LOSS_THRESH)) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (clr_cnt) begin
            word_cnt_d = '0;
        end else if (word_inc && (word_cnt_q != '1)) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = pulse_q;
    assign expected  = exp_q;
    assign word_cnt  = word_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule
